// File: rtl/inf_nec_rcv.sv
// NEC infrared receiver: pulse-width decoder for 32-bit frames and repeat codes.
// Define INF_EXT_ADDR_EN for extended NEC (16-bit address, no address-inverse check).
module inf_nec_rcv #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int TOL_PCT        = 20,
  parameter int SYNC_STAGES    = 2,
  parameter int RPT_TIMEOUT_MS = 120
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        inf_in,
  output logic        data_valid,
  output logic [15:0] addr,
  output logic [7:0]  cmd,
  output logic        repeat_en,
  output logic [7:0]  repeat_cnt,
  output logic        frame_err,
  output logic        busy
);

  function automatic longint win(input int w_us, input int pct);
    return (longint'(w_us) * longint'(CLK_FREQ) * longint'(pct)) / longint'(100_000_000);
  endfunction

  localparam longint LEAD_MAX = win(9000, 100 + TOL_PCT);
  localparam int     CNT_W    = $clog2(LEAD_MAX) + 1;
  localparam logic [CNT_W-1:0] L9_LO  = CNT_W'(win(9000, 100 - TOL_PCT));
  localparam logic [CNT_W-1:0] L9_HI  = CNT_W'(LEAD_MAX);
  localparam logic [CNT_W-1:0] L45_LO = CNT_W'(win(4500, 100 - TOL_PCT));
  localparam logic [CNT_W-1:0] L45_HI = CNT_W'(win(4500, 100 + TOL_PCT));
  localparam logic [CNT_W-1:0] R22_LO = CNT_W'(win(2250, 100 - TOL_PCT));
  localparam logic [CNT_W-1:0] R22_HI = CNT_W'(win(2250, 100 + TOL_PCT));
  localparam logic [CNT_W-1:0] B0_LO  = CNT_W'(win(560, 100 - TOL_PCT));
  localparam logic [CNT_W-1:0] B0_HI  = CNT_W'(win(560, 100 + TOL_PCT));
  localparam logic [CNT_W-1:0] B1_LO  = CNT_W'(win(1690, 100 - TOL_PCT));
  localparam logic [CNT_W-1:0] B1_HI  = CNT_W'(win(1690, 100 + TOL_PCT));

  localparam int MS_CYC = CLK_FREQ / 1000;
  localparam int MS_W   = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
  localparam int RPT_W  = $clog2(RPT_TIMEOUT_MS + 1);
  localparam logic [MS_W-1:0]  MS_LAST = MS_W'(MS_CYC - 1);
  localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(RPT_TIMEOUT_MS);

  function automatic logic in_win(input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] lo,
                                  input logic [CNT_W-1:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  typedef enum logic [2:0] {IDLE, LEAD_L, LEAD_H, BIT_L, BIT_H, STOP, RPT_S, ERR} state_t;

  state_t                   state_q;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     prev_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [CNT_W-1:0]         tmo_lim;
  logic [4:0]               bitcnt_q;
  logic [31:0]              sreg_q;
  logic [15:0]              addr_q;
  logic [7:0]               cmd_q, rcnt_q;
  logic                     dv_q, rp_q, fe_q, last_ok_q;
  logic [MS_W-1:0]          ms_q;
  logic [RPT_W-1:0]         rpt_tmr_q;
  logic                     line, rise, fall, timeout, cmd_ok, addr_ok, rpt_ok, is_one;
  logic [15:0]              addr_word;

  // Input synchroniser and edge detect: pure datapath, left out of reset so a
  // reset while the line is low cannot fabricate an edge afterwards.
  always_ff @(posedge sys_clk) begin
    sync_q <= {sync_q[SYNC_STAGES-2:0], inf_in};
    prev_q <= line;
  end

  assign line = sync_q[SYNC_STAGES-1];
  assign rise = line & ~prev_q;
  assign fall = ~line & prev_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst)            cnt_q <= '0;
    else if (rise || fall)  cnt_q <= '0;
    else if (cnt_q != '1)   cnt_q <= cnt_q + 1'b1;
  end

  always_comb begin
    tmo_lim = '1;
    case (state_q)
      LEAD_L:             tmo_lim = L9_HI;
      LEAD_H:             tmo_lim = L45_HI;
      BIT_H:              tmo_lim = B1_HI;
      BIT_L, STOP, RPT_S: tmo_lim = B0_HI;
      default:            tmo_lim = '1;
    endcase
  end

  assign timeout = cnt_q > tmo_lim;
  assign is_one  = in_win(cnt_q, B1_LO, B1_HI);
  assign cmd_ok  = (sreg_q[31:24] == ~sreg_q[23:16]);
  assign rpt_ok  = last_ok_q && (rpt_tmr_q < RPT_MAX);
`ifdef INF_EXT_ADDR_EN
  assign addr_ok   = 1'b1;
  assign addr_word = sreg_q[15:0];
`else
  assign addr_ok   = (sreg_q[15:8] == ~sreg_q[7:0]);
  assign addr_word = {8'h00, sreg_q[7:0]};
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      bitcnt_q  <= '0;
      sreg_q    <= '0;
      addr_q    <= '0;
      cmd_q     <= '0;
      rcnt_q    <= '0;
      dv_q      <= 1'b0;
      rp_q      <= 1'b0;
      fe_q      <= 1'b0;
      last_ok_q <= 1'b0;
      ms_q      <= '0;
      rpt_tmr_q <= '0;
    end else begin
      dv_q <= 1'b0;
      rp_q <= 1'b0;
      fe_q <= 1'b0;
      if (last_ok_q) begin
        if (ms_q == MS_LAST) begin
          ms_q <= '0;
          if (rpt_tmr_q != RPT_MAX) rpt_tmr_q <= rpt_tmr_q + 1'b1;
          if (rpt_tmr_q == RPT_MAX - 1'b1) last_ok_q <= 1'b0;
        end else begin
          ms_q <= ms_q + 1'b1;
        end
      end
      if (timeout) begin
        state_q <= ERR;
        fe_q    <= 1'b1;
      end else begin
        case (state_q)
          IDLE:   if (fall) state_q <= LEAD_L;
          LEAD_L: if (rise) begin
            if (in_win(cnt_q, L9_LO, L9_HI)) state_q <= LEAD_H;
            else begin state_q <= ERR; fe_q <= 1'b1; end
          end
          LEAD_H: if (fall) begin
            bitcnt_q <= '0;
            if (in_win(cnt_q, L45_LO, L45_HI))      state_q <= BIT_L;
            else if (in_win(cnt_q, R22_LO, R22_HI)) state_q <= RPT_S;
            else begin state_q <= ERR; fe_q <= 1'b1; end
          end
          BIT_L: if (rise) begin
            if (in_win(cnt_q, B0_LO, B0_HI)) state_q <= BIT_H;
            else begin state_q <= ERR; fe_q <= 1'b1; end
          end
          BIT_H: if (fall) begin
            if (is_one || in_win(cnt_q, B0_LO, B0_HI)) begin
              sreg_q   <= {is_one, sreg_q[31:1]};
              bitcnt_q <= bitcnt_q + 5'd1;
              state_q  <= (bitcnt_q == 5'd31) ? STOP : BIT_L;
            end else begin
              state_q <= ERR;
              fe_q    <= 1'b1;
            end
          end
          STOP: if (rise) begin
            if (!in_win(cnt_q, B0_LO, B0_HI)) begin
              state_q <= ERR;
              fe_q    <= 1'b1;
            end else begin
              state_q <= IDLE;
              if (cmd_ok && addr_ok) begin
                addr_q    <= addr_word;
                cmd_q     <= sreg_q[23:16];
                dv_q      <= 1'b1;
                rcnt_q    <= '0;
                last_ok_q <= 1'b1;
                rpt_tmr_q <= '0;
                ms_q      <= '0;
              end else begin
                fe_q <= 1'b1;
              end
            end
          end
          RPT_S: if (rise) begin
            if (!in_win(cnt_q, B0_LO, B0_HI)) begin
              state_q <= ERR;
              fe_q    <= 1'b1;
            end else begin
              state_q <= IDLE;
              // A stale repeat (no recent frame) is dropped without any pulse.
              if (rpt_ok) begin
                rp_q      <= 1'b1;
                rcnt_q    <= sat_inc8(rcnt_q);
                rpt_tmr_q <= '0;
                ms_q      <= '0;
              end
            end
          end
          ERR:     state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign data_valid = dv_q;
  assign repeat_en  = rp_q;
  assign frame_err  = fe_q;
  assign addr       = addr_q;
  assign cmd        = cmd_q;
  assign repeat_cnt = rcnt_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_inf_nec_rcv.sv
// Directed bench for inf_nec_rcv with CLK_FREQ=50 kHz (one clock = 20 us) so
// full NEC frames stay short; honours INF_EXT_ADDR_EN like the design.
`timescale 1ns/1ps
module tb_inf_nec_rcv;
  logic        clk = 1'b0;
  logic        rst;
  logic        inf_in;
  logic        data_valid, repeat_en, frame_err, busy;
  logic [15:0] addr;
  logic [7:0]  cmd, repeat_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int dv_n = 0, rp_n = 0, fe_n = 0;

  inf_nec_rcv #(
    .CLK_FREQ(50_000), .TOL_PCT(20), .SYNC_STAGES(2), .RPT_TIMEOUT_MS(120)
  ) dut (
    .sys_clk(clk), .sys_rst(rst), .inf_in(inf_in),
    .data_valid(data_valid), .addr(addr), .cmd(cmd),
    .repeat_en(repeat_en), .repeat_cnt(repeat_cnt),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_valid) dv_n++;
    if (repeat_en)  rp_n++;
    if (frame_err)  fe_n++;
    if (data_valid || repeat_en || frame_err) begin
      n_cmp++;
      assert ($onehot({data_valid, repeat_en, frame_err})) else begin
        n_bad++;
        $error("FAIL pulse_excl: observed %b expected one-hot", {data_valid, repeat_en, frame_err});
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    inf_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] fw(input logic [7:0] a, input logic [7:0] c);
    return {~c, c, ~a, a};
  endfunction

  task automatic send_bits(input logic [31:0] w, input int nbits);
    hold(1'b0, 450);
    hold(1'b1, 225);
    for (int i = 0; i < nbits; i++) begin
      hold(1'b0, 28);
      hold(1'b1, w[i] ? 84 : 28);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    send_bits(w, 32);
    hold(1'b0, 28);
    inf_in = 1'b1;
  endtask

  task automatic send_rpt();
    hold(1'b0, 450);
    hold(1'b1, 112);
    hold(1'b0, 28);
    inf_in = 1'b1;
  endtask

  initial begin
    inf_in = 1'b1;
    rst    = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_cmd", 32'(cmd), 32'd0);
    chk("rst_rcnt", 32'(repeat_cnt), 32'd0);
    chk("rst_pulses", 32'({data_valid, repeat_en, frame_err}), 32'd0);
    hold(1'b1, 20);

    // Frame 0x57/0x22 with exact output latency
    send_word(fw(8'h57, 8'h22));
    chk("busy_frame_end", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    chk("dv_early", 32'(data_valid), 32'd0);
    @(negedge clk);
    chk("dv_latency", 32'(data_valid), 32'd1);
    @(negedge clk);
    chk("dv_one_cycle", 32'(data_valid), 32'd0);
    hold(1'b1, 2096);
    chk("f1_dv_n", 32'(dv_n), 32'd1);
    chk("f1_addr", 32'(addr), 32'h0057);
    chk("f1_cmd", 32'(cmd), 32'h22);
    chk("f1_rcnt", 32'(repeat_cnt), 32'd0);
    chk("f1_fe_n", 32'(fe_n), 32'd0);

    // Two repeats inside the timeout window
    send_rpt();
    hold(1'b1, 4800);
    chk("r1_rp_n", 32'(rp_n), 32'd1);
    send_rpt();
    hold(1'b1, 10);
    chk("r2_rp_n", 32'(rp_n), 32'd2);
    chk("r2_rcnt", 32'(repeat_cnt), 32'd2);
    chk("r2_addr", 32'(addr), 32'h0057);
    chk("r2_cmd", 32'(cmd), 32'h22);
    chk("r2_fe_n", 32'(fe_n), 32'd0);

    // Late repeat is silently dropped
    hold(1'b1, 7500);
    send_rpt();
    hold(1'b1, 10);
    chk("late_rp_n", 32'(rp_n), 32'd2);
    chk("late_fe_n", 32'(fe_n), 32'd0);
    chk("late_rcnt", 32'(repeat_cnt), 32'd2);
    chk("late_busy", 32'(busy), 32'd0);

    // Bad command inverse, then short lead, then a good frame
    send_word({8'hDC, 8'h22, 8'hA8, 8'h57});
    hold(1'b1, 10);
    chk("badcmd_fe_n", 32'(fe_n), 32'd1);
    chk("badcmd_dv_n", 32'(dv_n), 32'd1);
    chk("badcmd_addr", 32'(addr), 32'h0057);
    chk("badcmd_cmd", 32'(cmd), 32'h22);
    hold(1'b0, 250);
    hold(1'b1, 10);
    chk("shortlead_fe_n", 32'(fe_n), 32'd2);
    send_word(fw(8'h10, 8'h5A));
    hold(1'b1, 10);
    chk("f2_dv_n", 32'(dv_n), 32'd2);
    chk("f2_addr", 32'(addr), 32'h0010);
    chk("f2_cmd", 32'(cmd), 32'h5A);
    chk("f2_rcnt", 32'(repeat_cnt), 32'd0);
    chk("f2_fe_n", 32'(fe_n), 32'd2);

    // Reset in the middle of bit 12
    send_bits(fw(8'h57, 8'h22), 12);
    hold(1'b0, 14);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_addr", 32'(addr), 32'd0);
    chk("mid_rst_cmd", 32'(cmd), 32'd0);
    chk("mid_rst_rcnt", 32'(repeat_cnt), 32'd0);
    chk("mid_rst_pulses", 32'({data_valid, repeat_en, frame_err}), 32'd0);
    hold(1'b0, 13);
    hold(1'b1, 200);
    chk("mid_rst_fe_n", 32'(fe_n), 32'd2);
    chk("mid_rst_dv_n", 32'(dv_n), 32'd2);
    send_word(fw(8'h57, 8'h22));
    hold(1'b1, 10);
    chk("f3_dv_n", 32'(dv_n), 32'd3);
    chk("f3_addr", 32'(addr), 32'h0057);
    chk("f3_cmd", 32'(cmd), 32'h22);

    // Address bytes 0x34 / 0x12 (not an inverse pair)
    send_word({8'hDD, 8'h22, 8'h12, 8'h34});
    hold(1'b1, 10);
`ifdef INF_EXT_ADDR_EN
    chk("ext_dv_n", 32'(dv_n), 32'd4);
    chk("ext_addr", 32'(addr), 32'h1234);
    chk("ext_fe_n", 32'(fe_n), 32'd2);
`else
    chk("std_dv_n", 32'(dv_n), 32'd3);
    chk("std_addr", 32'(addr), 32'h0057);
    chk("std_fe_n", 32'(fe_n), 32'd3);
`endif

    // Lead low held far past its window: timeout while still low
    hold(1'b0, 600);
    chk("tmo_busy", 32'(busy), 32'd0);
    hold(1'b1, 10);
`ifdef INF_EXT_ADDR_EN
    chk("tmo_fe_n", 32'(fe_n), 32'd3);
`else
    chk("tmo_fe_n", 32'(fe_n), 32'd4);
`endif
    chk("tmo_rp_n", 32'(rp_n), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
